// File: rtl/float_cls_pkg.sv
// Shared definitions for the streaming IEEE-754 classifier.
//   CLASS_W    : width of the one-hot class vector (RISC-V fclass order)
//   CLS_*      : bit index of each class inside the one-hot vector
//   fp_class_t : one-hot class type
package float_cls_pkg;

   localparam int unsigned CLASS_W = 10;

   localparam int unsigned CLS_NINF  = 0;
   localparam int unsigned CLS_NNORM = 1;
   localparam int unsigned CLS_NSUB  = 2;
   localparam int unsigned CLS_NZERO = 3;
   localparam int unsigned CLS_PZERO = 4;
   localparam int unsigned CLS_PSUB  = 5;
   localparam int unsigned CLS_PNORM = 6;
   localparam int unsigned CLS_PINF  = 7;
   localparam int unsigned CLS_SNAN  = 8;
   localparam int unsigned CLS_QNAN  = 9;

   typedef logic [CLASS_W-1:0] fp_class_t;

endpackage

// File: rtl/float_classify_stream_if.sv
// Operand/class stream bundle for float_classify_stream.
//   in_valid/in_ready/in_data     : operand stream into the classifier
//   out_valid/out_ready           : class stream out of the classifier
//   out_class/out_data            : one-hot class and the operand it belongs to
// Modports: master = operand source / class sink, slave = classifier.
interface float_classify_stream_if import float_cls_pkg::*; #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
);
   localparam int unsigned W = EXP_W + MAN_W + 1;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   fp_class_t    out_class;
   logic [W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_class, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_class, out_data
   );

endinterface

// File: rtl/float_classify_comb.sv
// Purely combinational IEEE-754 class decode.
//   data : operand, sign = [EXP_W+MAN_W], exp = [EXP_W+MAN_W-1:MAN_W], frac = [MAN_W-1:0]
//   cls  : one-hot class in RISC-V fclass order
module float_classify_comb import float_cls_pkg::*; #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] data,
   output fp_class_t            cls
);

   logic             sign;
   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] frac;
   logic             exp_zero;
   logic             exp_ones;
   logic             frac_zero;

   assign sign      = data[EXP_W+MAN_W];
   assign exp_f     = data[EXP_W+MAN_W-1:MAN_W];
   assign frac      = data[MAN_W-1:0];
   assign exp_zero  = (exp_f == '0);
   assign exp_ones  = &exp_f;
   assign frac_zero = (frac == '0);

   always_comb begin
      cls = '0;
      if (exp_ones) begin
         if (frac_zero) begin
            cls[sign ? CLS_NINF : CLS_PINF] = 1'b1;
         end else begin
            // Quiet bit is the fraction MSB; sign plays no part for NaN.
            cls[frac[MAN_W-1] ? CLS_QNAN : CLS_SNAN] = 1'b1;
         end
      end else if (exp_zero) begin
         if (frac_zero) begin
            cls[sign ? CLS_NZERO : CLS_PZERO] = 1'b1;
         end else begin
            cls[sign ? CLS_NSUB : CLS_PSUB] = 1'b1;
         end
      end else begin
         cls[sign ? CLS_NNORM : CLS_PNORM] = 1'b1;
      end
   end

endmodule

// File: rtl/float_classify_stream.sv
// Streaming IEEE-754 classifier: 2-stage valid/ready pipeline plus per-class
// saturating occurrence counters.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   bus         : operand in / class out stream (slave modport)
//   clr_stats   : synchronous clear of all counters (wins over a same-cycle count)
//   stat_sel    : counter select, 0..9 valid, 10..15 read as zero
//   stat_count  : selected counter value as of the last edge
module float_classify_stream import float_cls_pkg::*; #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   float_classify_stream_if.slave bus,
   input  logic                   clr_stats,
   input  logic [3:0]             stat_sel,
   output logic [CNT_W-1:0]       stat_count
);

   localparam int unsigned W = EXP_W + MAN_W + 1;

   logic             s1_valid_q;
   logic [W-1:0]     s1_data_q;
   logic             s2_valid_q;
   logic [W-1:0]     s2_data_q;
   fp_class_t        s2_class_q;
   fp_class_t        s1_class;
   logic             s1_load;
   logic             s2_load;
   logic             in_fire;
   logic             out_fire;
   logic [CNT_W-1:0] cnt_q [CLASS_W];

   // A stage may load when empty or when its contents leave on the same edge.
   assign s2_load  = !s2_valid_q || bus.out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_fire  = bus.in_valid && s1_load;
   assign out_fire = s2_valid_q && bus.out_ready;

   assign bus.in_ready  = s1_load;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_class = s2_class_q;
   assign bus.out_data  = s2_data_q;

   float_classify_comb #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_classify (
      .data (s1_data_q),
      .cls  (s1_class)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_class_q <= '0;
      end else begin
         if (s1_load) begin
            s1_valid_q <= bus.in_valid;
         end
         if (in_fire) begin
            s1_data_q <= bus.in_data;
         end
         if (s2_load) begin
            s2_valid_q <= s1_valid_q;
         end
         if (s2_load && s1_valid_q) begin
            s2_data_q  <= s1_data_q;
            s2_class_q <= s1_class;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < CLASS_W; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (clr_stats) begin
         for (int unsigned i = 0; i < CLASS_W; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (out_fire) begin
         for (int unsigned i = 0; i < CLASS_W; i++) begin
            // Saturate at all-ones instead of wrapping.
            if (s2_class_q[i] && (cnt_q[i] != '1)) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      stat_count = '0;
      if (stat_sel < 4'(CLASS_W)) begin
         stat_count = cnt_q[stat_sel];
      end
   end

endmodule

// File: tb/tb_float_classify_stream.sv
// Self-checking bench for float_classify_stream: a queue-based reference model
// of the stream and counters, checked every negedge, plus directed cases.
module tb_float_classify_stream;
   import float_cls_pkg::*;

   localparam int unsigned CW   = 4;
   localparam int          CMAX = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          clr_stats;
   logic [3:0]    stat_sel;
   logic [CW-1:0] stat_count;
   logic          h_clr;
   logic [3:0]    h_sel;
   logic [15:0]   h_cnt;

   always #5 clk = ~clk;

   float_classify_stream_if #(.EXP_W(8), .MAN_W(23)) bus ();
   float_classify_stream_if #(.EXP_W(5), .MAN_W(10)) hbus ();

   float_classify_stream #(.EXP_W(8), .MAN_W(23), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .clr_stats  (clr_stats),
      .stat_sel   (stat_sel),
      .stat_count (stat_count)
   );

   float_classify_stream #(.EXP_W(5), .MAN_W(10), .CNT_W(16)) dut_h (
      .clk        (clk),
      .reset      (reset),
      .bus        (hbus),
      .clr_stats  (h_clr),
      .stat_sel   (h_sel),
      .stat_count (h_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Class index straight from the IEEE-754 field rules.
   function automatic int ref_idx(input logic [63:0] d, input int ew, input int mw);
      longint unsigned emax, e, f;
      logic s;
      emax = (64'd1 << ew) - 64'd1;
      e    = (d >> mw) & emax;
      f    = d & ((64'd1 << mw) - 64'd1);
      s    = d[ew+mw];
      if (e == emax) begin
         if (f == 0) return s ? 0 : 7;
         return d[mw-1] ? 9 : 8;
      end
      if (e == 0) begin
         if (f == 0) return s ? 3 : 4;
         return s ? 2 : 5;
      end
      return s ? 1 : 6;
   endfunction

   function automatic logic [9:0] ref_class(input logic [63:0] d, input int ew, input int mw);
      logic [9:0] r;
      r = '0;
      r[ref_idx(d, ew, mw)] = 1'b1;
      return r;
   endfunction

   typedef struct {
      logic [31:0] d;
      int          idx;
      int          acc;
   } item_t;

   item_t q[$];
   int    mcnt[10];
   int    ncyc     = 0;
   int    last_low = -1000;

   // Reference model: the DUT holds at most two operands; order is preserved.
   always @(negedge clk) begin : mon
      item_t it;
      logic  exp_rdy;
      int    exp_cnt;
      ncyc++;
      if (reset) begin
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_in_ready", bus.in_ready, 1);
         chk("rst_out_class", bus.out_class, 0);
         chk("rst_out_data", bus.out_data, 0);
         chk("rst_stat_count", stat_count, 0);
         q.delete();
         for (int i = 0; i < 10; i++) mcnt[i] = 0;
      end else begin
         exp_rdy = (q.size() < 2) || bus.out_ready;
         chk("in_ready", bus.in_ready, exp_rdy);
         if (q.size() == 0) begin
            chk("idle_out_valid", bus.out_valid, 0);
         end else if (q.size() == 2 || (q[0].acc + 2 <= ncyc && last_low < q[0].acc)) begin
            chk("out_valid_due", bus.out_valid, 1);
         end
         if (bus.out_valid && q.size() > 0) begin
            chk("out_class", bus.out_class, 64'd1 << q[0].idx);
            chk("out_data", bus.out_data, q[0].d);
         end
         exp_cnt = (stat_sel < 10) ? mcnt[stat_sel] : 0;
         chk("stat_count", stat_count, exp_cnt);
         if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            it = q.pop_front();
            if (!clr_stats && mcnt[it.idx] < CMAX) mcnt[it.idx]++;
         end
         if (clr_stats) begin
            for (int i = 0; i < 10; i++) mcnt[i] = 0;
         end
         if (bus.in_valid && exp_rdy) begin
            it.d   = bus.in_data;
            it.idx = ref_idx(64'(bus.in_data), 8, 23);
            it.acc = ncyc;
            q.push_back(it);
         end
         if (!bus.out_ready) last_low = ncyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic push(input logic [31:0] d);
      int   t;
      logic acc;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      t = 0;
      forever begin
         @(negedge clk);
         acc = bus.in_ready;
         step();
         if (acc) break;
         t++;
         if (t > 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stayed 0, required 1 within 40 cycles");
            break;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rnd_data();
      logic [7:0]  e;
      logic [22:0] f;
      case ($urandom_range(0, 3))
         0:       e = 8'h00;
         1:       e = 8'hFF;
         default: e = 8'($urandom_range(1, 254));
      endcase
      case ($urandom_range(0, 3))
         0:       f = '0;
         1:       f = {1'b1, 22'($urandom)};
         2:       f = {1'b0, 22'($urandom)};
         default: f = 23'($urandom);
      endcase
      return {1'($urandom), e, f};
   endfunction

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, required finish before 400000");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      reset          = 1'b1;
      clr_stats      = 1'b0;
      stat_sel       = 4'd6;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b1;
      h_clr          = 1'b0;
      h_sel          = 4'd0;
      hbus.in_valid  = 1'b0;
      hbus.in_data   = '0;
      hbus.out_ready = 1'b1;

      // Pin the reference model with hand-derived classes.
      chk("pin_pzero", ref_class(64'h00000000, 8, 23), 10'h010);
      chk("pin_nzero", ref_class(64'h80000000, 8, 23), 10'h008);
      chk("pin_pnorm", ref_class(64'h3F800000, 8, 23), 10'h040);
      chk("pin_psub",  ref_class(64'h00000001, 8, 23), 10'h020);
      chk("pin_ninf",  ref_class(64'hFF800000, 8, 23), 10'h001);
      chk("pin_snan",  ref_class(64'h7F800001, 8, 23), 10'h100);
      chk("pin_qnan_neg", ref_class(64'hFFC00000, 8, 23), 10'h200);
      chk("pin_half_qnan", ref_class(64'hFE00, 5, 10), 10'h200);

      idle(3);
      reset = 1'b0;

      // Basic vectors and NaN split, full throughput.
      push(32'h00000000);
      push(32'h80000000);
      push(32'h3F800000);
      push(32'h00000001);
      push(32'hFF800000);
      push(32'h7FC00000);
      push(32'h7F800001);
      push(32'hFFC00000);
      idle(4);

      // Backpressure mid-stream.
      fork
         begin
            push(32'h3F800000);
            push(32'hBF800000);
            push(32'h00000001);
            push(32'h7FC00000);
         end
         begin
            @(posedge clk);
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      idle(4);
      stat_sel = 4'd9;
      @(negedge clk) chk("bp_cnt_qnan", stat_count, 3);
      step();
      stat_sel = 4'd6;
      @(negedge clk) chk("bp_cnt_pnorm", stat_count, 2);
      step();
      stat_sel = 4'd5;
      @(negedge clk) chk("bp_cnt_psub", stat_count, 2);
      step();
      stat_sel = 4'd12;
      @(negedge clk) chk("sel_out_of_range", stat_count, 0);
      step();

      // Saturation at 15, then clear racing a handshake.
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      stat_sel  = 4'd6;
      repeat (20) push(32'h3F800000);
      idle(4);
      @(negedge clk) chk("sat_cnt6", stat_count, 15);
      step();
      bus.out_ready = 1'b0;
      push(32'h3F800000);
      idle(2);
      bus.out_ready = 1'b1;
      clr_stats     = 1'b1;
      step();
      clr_stats = 1'b0;
      for (int i = 0; i < 10; i++) begin
         stat_sel = 4'(i);
         @(negedge clk) chk("clr_cnt", stat_count, 0);
         step();
      end

      // Randomized traffic.
      repeat (400) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.in_data   = rnd_data();
         bus.out_ready = ($urandom_range(0, 9) < 7);
         clr_stats     = ($urandom_range(0, 49) == 0);
         stat_sel      = 4'($urandom_range(0, 15));
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      clr_stats     = 1'b0;
      idle(4);

      // Reset with both stages full and a third operand waiting.
      bus.out_ready = 1'b0;
      push(32'h3F800000);
      push(32'h00000001);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hC0000000;
      step();
      reset         = 1'b1;
      bus.out_ready = 1'b1;
      stat_sel      = 4'd6;
      @(negedge clk);
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_in_ready", bus.in_ready, 1);
      chk("mid_rst_cnt", stat_count, 0);
      step();
      reset = 1'b0;
      @(negedge clk) chk("post_rst_in_ready", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      @(negedge clk) chk("post_rst_lat1", bus.out_valid, 0);
      @(negedge clk);
      chk("post_rst_lat2", bus.out_valid, 1);
      chk("post_rst_data", bus.out_data, 32'hC0000000);
      chk("post_rst_class", bus.out_class, 10'h002);
      step();
      idle(3);

      // Half precision.
      hbus.in_valid = 1'b1;
      hbus.in_data  = 16'h7C00;
      step();
      hbus.in_data = 16'h0001;
      step();
      hbus.in_data = 16'hFE00;
      @(negedge clk);
      chk("half_inf_valid", hbus.out_valid, 1);
      chk("half_inf", hbus.out_class, 10'h080);
      chk("half_inf_data", hbus.out_data, 16'h7C00);
      step();
      hbus.in_valid = 1'b0;
      @(negedge clk) chk("half_sub", hbus.out_class, 10'h020);
      @(negedge clk) chk("half_qnan", hbus.out_class, 10'h200);
      @(negedge clk) chk("half_drain", hbus.out_valid, 0);
      step();
      h_sel = 4'd9;
      @(negedge clk) chk("half_cnt_qnan", h_cnt, 1);
      step();
      h_sel = 4'd7;
      @(negedge clk) chk("half_cnt_pinf", h_cnt, 1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
